fib_bcd_conv: RTL and testbench
===============================

// Module: fib_bcd_conv
// PURPOSE
//  Downstream stage of the fibonacci generator: takes each binary result on its done pulse.
//  Converts the result to packed BCD with a sequential double-dabble (one bit per clock).
//  Presents the digits on a valid/ready output port for a display or print stage.
//  Decouples the generator from a slow consumer by holding one converted result.
// PARAMETERS
//  W       10  binary input width; matches the fibonacci result width
//  DIGITS  4   BCD digits out; must be >= ceil(W*log10(2)), else upper digits are lost
// PORTS
//  clk        in   1         clock; all logic on posedge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         input strobe; wired to fibonacci done (1-cycle pulse)
//  in_data    in   W         binary value; wired to fibonacci fib
//  in_ready   out  1         1 only in IDLE; input accepted when in_valid&&in_ready
//  busy       out  1         1 in SHIFT or HOLD
//  bcd_valid  out  1         1 in HOLD; bcd is stable while high
//  bcd_ready  in   1         consumer accepts bcd when bcd_valid&&bcd_ready
//  bcd        out  4*DIGITS  packed BCD; digit 0 in bcd[3:0]
//  drop_cnt   out  8         only with FIB_BCD_DROP_CNT_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset, sampled at posedge:
//   - state=IDLE; in_ready=1; busy=0; bcd_valid=0; bcd=0; shift reg=0; bit cnt=0
//   - reset wins over every other event, including mid-SHIFT and mid-HOLD
//  FSM states: IDLE, SHIFT, HOLD.
//  IDLE -> SHIFT on in_valid at edge k:
//   - load in_data into shift reg; clear the BCD accumulator; bit cnt=W
//  SHIFT, once per clock (edges k+1 .. k+W):
//   - per digit: if digit>=5, add 3 (digit 4 bits, no carry out)
//   - then shift {acc,sreg} left 1; bit cnt-=1
//   - when bit cnt reaches 0: bcd<=acc and go to HOLD
//  bcd_valid is high from edge k+W: latency is W clocks from accept to valid.
//  HOLD:
//   - bcd and bcd_valid hold indefinitely while bcd_ready=0
//   - on bcd_valid&&bcd_ready -> IDLE; bcd_valid drops next cycle
//   - bcd keeps its last value until the next conversion completes
//  in_valid outside IDLE is ignored; the value is lost (in_valid is a pulse, no buffering).
//  in_valid in the cycle right after a HOLD handshake is accepted (in_ready already 1).
//  in_data matters only in the accept cycle; X elsewhere is legal.
//  Boundaries (W=10, DIGITS=4):
//   - in_data=0 gives bcd=16'h0000 after W clocks
//   - in_data=1023 gives bcd=16'h1023
//   - DIGITS too small: high digits truncated silently; integration must size it
//  bcd_ready while not in HOLD has no effect.
// CONFIGURATION
//  FIB_BCD_DROP_CNT_EN defined:
//   - drop_cnt port present; 8-bit counter, reset to 0
//   - +1 on each cycle with in_valid=1 and in_ready=0; saturates at 255
//  FIB_BCD_DROP_CNT_EN undefined:
//   - no drop_cnt port, no counter logic; dropped inputs go uncounted
// TESTING
//  1. in_data=55 pulse, bcd_ready=1 -> bcd_valid exactly 10 clocks later, bcd=16'h0055, 1 cycle
//  2. in_data=1023, then in_data=0 -> bcd=16'h1023, then 16'h0000; in_ready=0 during SHIFT
//  3. bcd_ready=0 for 6 clocks in HOLD -> bcd_valid and bcd stable; IDLE the edge after ready=1
//  4. second in_valid at accept+3 (in_data=89) -> ignored, bcd=first value; drop_cnt=1 if EN
//  5. rst=1 at accept+4 (mid-SHIFT) -> next cycle IDLE, bcd=0, bcd_valid=0, in_ready=1
//  6. handshake, then in_valid next cycle (in_data=144) -> accepted, bcd=16'h0144 after 10 clocks

Source files
------------

// File: rtl/fib_bcd_conv.sv
// -----------------------------------------------------------------------------
// fib_bcd_conv
//   Binary-to-packed-BCD converter placed after the fibonacci generator.
//   A result is captured on its in_valid pulse. It is converted with a
//   sequential double-dabble that handles one input bit per clock. It is then
//   held on a valid/ready port until the consumer takes it. One converted
//   result is buffered, so a slow display/print stage does not stall the
//   generator's timing.
//
//   Optional feature macro: FIB_BCD_DROP_CNT_EN
//     defined   -> drop_cnt port plus a saturating 8-bit counter of inputs that
//                  arrived while the converter was not ready (lost values)
//     undefined -> no drop_cnt port and no counter logic
// -----------------------------------------------------------------------------
module fib_bcd_conv #(
   parameter int W      = 10,   // binary input width (fibonacci result width)
   parameter int DIGITS = 4     // BCD digits; must cover W bits or MSDs are lost
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [W-1:0]        in_data,
   output logic                in_ready,
   output logic                busy,
   output logic                bcd_valid,
   input  logic                bcd_ready,
   output logic [4*DIGITS-1:0] bcd
`ifdef FIB_BCD_DROP_CNT_EN
   ,
   output logic [7:0]          drop_cnt
`endif
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(W + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [W-1:0]       sreg;        // binary bits still to be shifted in
   logic [BCD_W-1:0]   acc;         // BCD accumulator under construction
   logic [CNT_W-1:0]   bit_cnt;     // bits remaining in the current conversion

   logic [BCD_W-1:0]   acc_adj;     // accumulator after the add-3 correction
   logic [BCD_W+W-1:0] dabble_wide; // {acc_adj, sreg} after one left shift
   logic [BCD_W-1:0]   acc_shift;
   logic [W-1:0]       sreg_shift;
   logic               last_bit;

   // Add 3 to every digit that is 5 or more, so the next shift left carries
   // into the digit above at exactly the decimal boundary. Each digit stays
   // 4 bits wide and has no carry out: a corrected digit is at most 12.
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // One double-dabble step: correct the digits, then shift {acc,sreg} left 1.
   always_comb begin
      // NOTE: every always_comb output gets a value before any branch, so no
      // path can leave it unassigned and infer a latch.
      acc_adj     = dabble_adjust(acc);
      dabble_wide = {acc_adj, sreg} << 1;
      acc_shift   = dabble_wide[BCD_W+W-1:W];
      sreg_shift  = dabble_wide[W-1:0];
      last_bit    = (bit_cnt == CNT_W'(1));
   end

   // State register; reset has priority over every transition.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the edge and the order of the
      // statements does not matter.
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next-state logic: accept in IDLE, run W shift steps, hold until the handshake.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (in_valid)  state_next = ST_SHIFT;
         ST_SHIFT: if (last_bit)  state_next = ST_HOLD;
         ST_HOLD:  if (bcd_ready) state_next = ST_IDLE;
         default:                 state_next = ST_IDLE;
      endcase
   end

   // Datapath: load on accept, shift once per clock, publish bcd on the last step.
   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset as well as the FSM. This makes
      // bcd read 0 after reset, and the shift state is never left unknown.
      if (rst) begin
         sreg    <= '0;
         acc     <= '0;
         bit_cnt <= '0;
         bcd     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sreg    <= in_data;
                  acc     <= '0;
                  bit_cnt <= CNT_W'(W);
               end
            end
            ST_SHIFT: begin
               sreg    <= sreg_shift;
               acc     <= acc_shift;
               bit_cnt <= bit_cnt - CNT_W'(1);
               if (last_bit)
                  bcd <= acc_shift;
            end
            default: begin
               // HOLD: bcd keeps its value until the next conversion finishes
            end
         endcase
      end
   end

   // Handshake and status outputs are decoded directly from the state.
   always_comb begin
      in_ready  = (state == ST_IDLE);
      busy      = (state == ST_SHIFT) || (state == ST_HOLD);
      bcd_valid = (state == ST_HOLD);
   end

`ifdef FIB_BCD_DROP_CNT_EN
   // Count input pulses lost while not ready; saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (in_valid && !in_ready && (drop_cnt != 8'hFF))
         drop_cnt <= drop_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_fib_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_fib_bcd_conv
//   Self-checking bench for fib_bcd_conv (W=10, DIGITS=4). Expected BCD values
//   come from decimal arithmetic on the input value (divide/modulo by powers of
//   ten). Latency and handshake timing are checked clock by clock. The drop
//   counter is checked when FIB_BCD_DROP_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fib_bcd_conv;

   localparam int W      = 10;
   localparam int DIGITS = 4;
   localparam int BCD_W  = 4 * DIGITS;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [W-1:0]     in_data;
   logic             in_ready;
   logic             busy;
   logic             bcd_valid;
   logic             bcd_ready;
   logic [BCD_W-1:0] bcd;
`ifdef FIB_BCD_DROP_CNT_EN
   logic [7:0]       drop_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int drop_exp = 0;   // expected lost-input count since the last reset

   fib_bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .busy      (busy),
      .bcd_valid (bcd_valid),
      .bcd_ready (bcd_ready),
      .bcd       (bcd)
`ifdef FIB_BCD_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Watchdog: the run must always end by itself.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: decimal digits of v, truncated to DIGITS digits.
   function automatic logic [BCD_W-1:0] to_bcd(input int v);
      logic [BCD_W-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full conversion. A drop_at value in 1..W+hold pulses in_valid (89) so that
   // edge accept+drop_at samples it. ready_early raises bcd_ready already
   // during SHIFT. hold gives the clocks of bcd_ready=0 after valid.
   task automatic run_one(input int v, input int hold, input int drop_at,
                          input bit ready_early, input string tag);
      logic [BCD_W-1:0] exp;
      exp       = to_bcd(v);
      bcd_ready = ready_early;
      in_valid  = 1'b1;
      in_data   = W'(v);
      step();                                   // accept edge k
      in_valid  = 1'b0;
      in_data   = 'x;
      n_checks++;
      if ({in_ready, busy, bcd_valid} !== 3'b010) begin
         n_errors++;
         $display("FAIL %s accept: {in_ready,busy,bcd_valid}=%b required 010",
                  tag, {in_ready, busy, bcd_valid});
      end
      for (int e = 1; e <= W + hold; e++) begin
         in_valid = (e == drop_at);
         in_data  = (e == drop_at) ? W'(89) : 'x;
         step();                                // edge k+e
         if (e == drop_at)
            drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
         if (e < W) begin
            n_checks++;
            if ({in_ready, busy, bcd_valid} !== 3'b010) begin
               n_errors++;
               $display("FAIL %s shift k+%0d: {in_ready,busy,bcd_valid}=%b required 010",
                        tag, e, {in_ready, busy, bcd_valid});
            end
         end else begin
            n_checks++;
            if ({in_ready, busy, bcd_valid} !== 3'b011 || bcd !== exp) begin
               n_errors++;
               $display("FAIL %s hold k+%0d: {in_ready,busy,bcd_valid}=%b bcd=%h required 011 bcd=%h",
                        tag, e, {in_ready, busy, bcd_valid}, bcd, exp);
            end
         end
      end
      in_valid  = 1'b0;
      bcd_ready = 1'b1;
      step();                                   // handshake edge
      bcd_ready = 1'b0;
      n_checks++;
      if ({in_ready, busy, bcd_valid} !== 3'b100 || bcd !== exp) begin
         n_errors++;
         $display("FAIL %s release: {in_ready,busy,bcd_valid}=%b bcd=%h required 100 bcd=%h",
                  tag, {in_ready, busy, bcd_valid}, bcd, exp);
      end
`ifdef FIB_BCD_DROP_CNT_EN
      n_checks++;
      if (drop_cnt !== 8'(drop_exp)) begin
         n_errors++;
         $display("FAIL %s drop_cnt: got %0d required %0d", tag, drop_cnt, drop_exp);
      end
`endif
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      bcd_ready = 1'b0;
      step();
      step();
      rst      = 1'b0;
      drop_exp = 0;
      n_checks++;
      if ({in_ready, busy, bcd_valid} !== 3'b100 || bcd !== '0) begin
         n_errors++;
         $display("FAIL reset: {in_ready,busy,bcd_valid}=%b bcd=%h required 100 bcd=0000",
                  {in_ready, busy, bcd_valid}, bcd);
      end
`ifdef FIB_BCD_DROP_CNT_EN
      n_checks++;
      if (drop_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL reset drop_cnt: got %0d required 0", drop_cnt);
      end
`endif
   endtask

   // 55 with bcd_ready already high: valid after exactly W clocks, for one cycle.
   task automatic test_single();
      run_one(55, 0, 0, 1'b1, "single55");
   endtask

   task automatic test_extremes();
      run_one(1023, 0, 0, 1'b0, "max1023");
      run_one(0, 0, 0, 1'b0, "zero");
   endtask

   task automatic test_hold();
      run_one(int'($urandom_range(0, 1023)), 6, 0, 1'b0, "hold6");
   endtask

   task automatic test_drop();
      run_one(233, 0, 3, 1'b0, "drop_shift");
      run_one(610, 3, W + 2, 1'b0, "drop_hold");
   endtask

   task automatic test_reset_mid();
      // Mid-SHIFT: accept at edge k, reset sampled at edge k+4.
      bcd_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(777);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst      = 1'b0;
      drop_exp = 0;
      n_checks++;
      if ({in_ready, busy, bcd_valid} !== 3'b100 || bcd !== '0) begin
         n_errors++;
         $display("FAIL reset_shift: {in_ready,busy,bcd_valid}=%b bcd=%h required 100 bcd=0000",
                  {in_ready, busy, bcd_valid}, bcd);
      end
      // Mid-HOLD: run to HOLD with bcd_ready low, then reset.
      in_valid = 1'b1;
      in_data  = W'(777);
      step();
      in_valid = 1'b0;
      repeat (W) step();
      n_checks++;
      if (bcd_valid !== 1'b1 || bcd !== to_bcd(777)) begin
         n_errors++;
         $display("FAIL reset_hold pre: bcd_valid=%b bcd=%h required 1 bcd=%h",
                  bcd_valid, bcd, to_bcd(777));
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if ({in_ready, busy, bcd_valid} !== 3'b100 || bcd !== '0) begin
         n_errors++;
         $display("FAIL reset_hold: {in_ready,busy,bcd_valid}=%b bcd=%h required 100 bcd=0000",
                  {in_ready, busy, bcd_valid}, bcd);
      end
`ifdef FIB_BCD_DROP_CNT_EN
      n_checks++;
      if (drop_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_mid drop_cnt: got %0d required 0", drop_cnt);
      end
`endif
   endtask

   // run_one raises in_valid in the cycle right after its handshake edge.
   task automatic test_back_to_back();
      run_one(377, 0, 0, 1'b0, "b2b_first");
      run_one(144, 0, 0, 1'b0, "b2b_144");
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         int v, hold, drop_at;
         bit early;
         v       = int'($urandom_range(0, 1023));
         hold    = int'($urandom_range(0, 4));
         drop_at = int'($urandom_range(0, W + hold));
         early   = (hold == 0) && ($urandom_range(0, 1) == 1);
         run_one(v, hold, drop_at, early, "random");
      end
   endtask

`ifdef FIB_BCD_DROP_CNT_EN
   // Hold in_valid high for 300 clocks in HOLD: the counter must stop at 255.
   task automatic test_drop_saturate();
      bcd_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(1);
      step();
      in_valid = 1'b0;
      repeat (W) step();
      in_valid = 1'b1;
      repeat (300) step();
      in_valid  = 1'b0;
      bcd_ready = 1'b1;
      step();
      bcd_ready = 1'b0;
      drop_exp  = 255;
      n_checks++;
      if (drop_cnt !== 8'd255 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL drop_saturate: drop_cnt=%0d in_ready=%b required 255 and 1",
                  drop_cnt, in_ready);
      end
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      bcd_ready = 1'b0;
      test_reset();
      test_single();
      test_extremes();
      test_hold();
      test_drop();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef FIB_BCD_DROP_CNT_EN
      test_drop_saturate();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
